serial_divider: RTL and testbench
=================================

Name: serial_divider

Overview:
- Sequential restoring divider; the inverse-direction companion to the team's shift-add serial multiplier.
- Shares that block's load/ctrl operating model: pulse load to capture operands, then hold ctrl high for N clocks, one quotient bit per clock.
- Sits beside the multiplier in the arithmetic lab datapath and produces quotient and remainder of unsigned N-bit operands.

Parameters:
- N, 4, operand width in bits for dividend, divisor, quotient and remainder (N >= 2).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- A  input  N  dividend, unsigned; sampled only when load=1.
- B  input  N  divisor, unsigned; sampled only when load=1.
- load  input  1  capture operands and initialise the datapath.
- ctrl  input  1  run enable; while high, one division step per clock.
- Q  output  N  quotient register; holds the dividend while running.
- R  output  N  remainder register (partial remainder while running).
- M  output  N  latched divisor register.
- QR  output  2N  concatenation {R,Q}.
- done  output  1  high once all N steps are complete.
- div_by_zero  output  1  divisor-zero flag; only active with the optional feature.

Behaviour:
- Reset: when rst_n=0 at a rising edge, Q, R, M, the step counter, done and div_by_zero all become 0. Reset has priority over load and ctrl.
- Load: when load=1 (rst_n=1), the next edge sets Q<=A, M<=B, R<=0, count<=0, done<=0. Load has priority over ctrl, so load during a run aborts and restarts.
- Step: when ctrl=1, load=0, done=0 and count<N, each edge does the following:
  - Form {R',Q'} = {R,Q} << 1 using an internal N+1-bit partial remainder.
  - Compute trial = R' - {1'b0,M}.
  - If trial >= 0: R<=trial, Q<={Q'[N-1:1],1}.
  - Else: R<=R' (restore), Q<={Q'[N-1:1],0}.
  - count<=count+1.
- Completion: on the edge performing step N, done<=1 together with the final Q and R.
- Latency: the final result is valid after the load edge plus N ctrl-enabled edges.
- After done: further ctrl=1 cycles change nothing. Q, R, M and done hold until the next load or reset.
- ctrl=0 mid-run: all registers hold. Stepping resumes exactly where it stopped when ctrl returns to 1; no steps are lost.
- Counter width: clog2(N+1). It never exceeds N.
- Result invariant at done: A = Q*B + R, with R < B (for B != 0).
- Outputs are registered only; no combinational path from any input to any output.

Optional Feature:
- Macro: SERIAL_DIVIDER_DIV_ZERO_DETECT_EN.
- Defined:
  - A load with B=0 sets div_by_zero<=1 and done<=1 on the load edge, with Q<=all ones, R<=A.
  - Subsequent ctrl cycles perform no steps.
  - A load with B!=0 clears div_by_zero.
- Undefined:
  - div_by_zero is tied to 0.
  - B=0 runs the normal N steps, and the algorithm naturally yields Q = 2^N-1, R = A at done.
- Either way, the final Q and R for B=0 are identical; only the flag and the timing of done differ.

Test Plan:
1. N=4, rst_n low for one edge, then A=13, B=4, load for one edge, ctrl high for 4 edges -> done=1 after the 4th edge; Q=3, R=1, QR=8'h13; Q/R/done stable across 3 further ctrl edges.
2. A=3, B=12, load then 4 ctrl edges -> Q=0, R=3, M=12. Then A=15, B=15, load then 4 ctrl edges -> Q=1, R=0, done=1.
3. A=14, B=3, load, ctrl high for 2 edges, low for 3 edges, high again -> registers frozen during the low window; done only after the 4th enabled edge; Q=4, R=2.
4. A=9, B=2, load, 2 ctrl edges, then load with A=15, B=15 while ctrl stays high -> restart: done=0; after 4 more edges Q=1, R=0.
5. Mid-run (after 2 ctrl edges), drive rst_n=0 for one edge -> Q=R=M=0 and done=0 on that edge; ctrl edges with no new load then yield Q=0, R=0.
6. A=11, B=0:
   - with SERIAL_DIVIDER_DIV_ZERO_DETECT_EN -> div_by_zero=1 and done=1 right after the load edge, with Q=15, R=11;
   - without the macro -> div_by_zero=0, done after 4 edges, Q=15, R=11.

Source files
------------

// File: rtl/serial_divider.sv
// Sequential restoring divider: one quotient bit per ctrl-enabled clock, N steps per load.
// Optional macro SERIAL_DIVIDER_DIV_ZERO_DETECT_EN flags B=0 and completes on the load edge.
module serial_divider #(
   parameter int N = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [N-1:0]   A,
   input  logic [N-1:0]   B,
   input  logic           load,
   input  logic           ctrl,
   output logic [N-1:0]   Q,
   output logic [N-1:0]   R,
   output logic [N-1:0]   M,
   output logic [2*N-1:0] QR,
   output logic           done,
   output logic           div_by_zero
);

   localparam int CW = $clog2(N + 1);
   localparam logic [CW-1:0] LAST_STEP = CW'(N - 1);
   localparam logic [CW-1:0] NUM_STEPS = CW'(N);

   logic [N-1:0]   r_q;
   logic [N-1:0]   r_r;
   logic [N-1:0]   r_m;
   logic [CW-1:0]  r_cnt;
   logic           r_done;
   logic [2*N-1:0] w_next;
   logic           w_step;

   // One restoring step; returns {remainder, quotient}. The N+1-bit shifted
   // remainder is compared in full, and since the kept difference is always
   // below the divisor (or equals the shifted value when M=0) N bits suffice.
   function automatic logic [2*N-1:0] div_step(input logic [N-1:0] rem,
                                               input logic [N-1:0] quo,
                                               input logic [N-1:0] div);
      logic [N:0]   shr;
      logic [N-1:0] trial;
      shr   = {rem, quo[N-1]};
      trial = shr[N-1:0] - div;
      if (shr >= {1'b0, div})
         div_step = {trial, quo[N-2:0], 1'b1};
      else
         div_step = {shr[N-1:0], quo[N-2:0], 1'b0};
   endfunction

   assign w_step = ctrl && !r_done && (r_cnt < NUM_STEPS);
   assign w_next = div_step(r_r, r_q, r_m);

`ifdef SERIAL_DIVIDER_DIV_ZERO_DETECT_EN
   logic r_dbz;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_q    <= '0;
         r_r    <= '0;
         r_m    <= '0;
         r_cnt  <= '0;
         r_done <= 1'b0;
`ifdef SERIAL_DIVIDER_DIV_ZERO_DETECT_EN
         r_dbz  <= 1'b0;
`endif
      end else if (load) begin
         r_q    <= A;
         r_m    <= B;
         r_r    <= '0;
         r_cnt  <= '0;
         r_done <= 1'b0;
`ifdef SERIAL_DIVIDER_DIV_ZERO_DETECT_EN
         r_dbz  <= (B == '0);
         if (B == '0) begin
            r_q    <= '1;
            r_r    <= A;
            r_done <= 1'b1;
         end
`endif
      end else if (w_step) begin
         r_r   <= w_next[2*N-1:N];
         r_q   <= w_next[N-1:0];
         r_cnt <= r_cnt + CW'(1);
         if (r_cnt == LAST_STEP)
            r_done <= 1'b1;
      end
   end

   assign Q    = r_q;
   assign R    = r_r;
   assign M    = r_m;
   assign QR   = {r_r, r_q};
   assign done = r_done;
`ifdef SERIAL_DIVIDER_DIV_ZERO_DETECT_EN
   assign div_by_zero = r_dbz;
`else
   assign div_by_zero = 1'b0;
`endif

endmodule

// File: tb/tb_serial_divider.sv
// Directed bench for serial_divider (N=4) with hand-computed expected values.
module tb_serial_divider;

   localparam int N = 4;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [N-1:0]   A;
   logic [N-1:0]   B;
   logic           load;
   logic           ctrl;
   logic [N-1:0]   Q;
   logic [N-1:0]   R;
   logic [N-1:0]   M;
   logic [2*N-1:0] QR;
   logic           done;
   logic           div_by_zero;

   int errors = 0;
   int checks = 0;

   serial_divider #(.N(N)) dut (
      .clk(clk), .rst_n(rst_n), .A(A), .B(B), .load(load), .ctrl(ctrl),
      .Q(Q), .R(R), .M(M), .QR(QR), .done(done), .div_by_zero(div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_load(input logic [N-1:0] a, input logic [N-1:0] b);
      A = a; B = b; load = 1'b1;
      tick();
      load = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; A = '0; B = '0; load = 1'b0; ctrl = 1'b0;
      tick();
      check("rst_Q", 32'(Q), 0);
      check("rst_R", 32'(R), 0);
      check("rst_M", 32'(M), 0);
      check("rst_done", 32'(done), 0);
      check("rst_dbz", 32'(div_by_zero), 0);
      rst_n = 1'b1;

      // 13 / 4
      do_load(4'd13, 4'd4);
      check("t1_load_Q", 32'(Q), 13);
      check("t1_load_R", 32'(R), 0);
      check("t1_load_M", 32'(M), 4);
      check("t1_load_done", 32'(done), 0);
      ctrl = 1'b1;
      tick(2);
      check("t1_mid_Q", 32'(Q), 4);
      check("t1_mid_R", 32'(R), 3);
      tick();
      check("t1_step3_done", 32'(done), 0);
      tick();
      check("t1_done", 32'(done), 1);
      check("t1_Q", 32'(Q), 3);
      check("t1_R", 32'(R), 1);
      check("t1_QR", 32'(QR), 32'h13);
      tick(3);
      check("t1_hold_Q", 32'(Q), 3);
      check("t1_hold_R", 32'(R), 1);
      check("t1_hold_done", 32'(done), 1);

      // 3 / 12 and 15 / 15
      ctrl = 1'b0;
      do_load(4'd3, 4'd12);
      ctrl = 1'b1;
      tick(4);
      check("t2a_Q", 32'(Q), 0);
      check("t2a_R", 32'(R), 3);
      check("t2a_M", 32'(M), 12);
      check("t2a_done", 32'(done), 1);
      ctrl = 1'b0;
      do_load(4'd15, 4'd15);
      ctrl = 1'b1;
      tick(4);
      check("t2b_Q", 32'(Q), 1);
      check("t2b_R", 32'(R), 0);
      check("t2b_done", 32'(done), 1);

      // 14 / 3 with a ctrl-low pause after two steps
      ctrl = 1'b0;
      do_load(4'd14, 4'd3);
      ctrl = 1'b1;
      tick(2);
      check("t3_s2_Q", 32'(Q), 9);
      check("t3_s2_R", 32'(R), 0);
      ctrl = 1'b0;
      tick(3);
      check("t3_pause_Q", 32'(Q), 9);
      check("t3_pause_R", 32'(R), 0);
      check("t3_pause_done", 32'(done), 0);
      ctrl = 1'b1;
      tick();
      check("t3_s3_done", 32'(done), 0);
      check("t3_s3_Q", 32'(Q), 2);
      tick();
      check("t3_done", 32'(done), 1);
      check("t3_Q", 32'(Q), 4);
      check("t3_R", 32'(R), 2);

      // 9 / 2 aborted by a reload of 15 / 15 with ctrl held high
      ctrl = 1'b0;
      do_load(4'd9, 4'd2);
      ctrl = 1'b1;
      tick(2);
      do_load(4'd15, 4'd15);
      check("t4_restart_done", 32'(done), 0);
      check("t4_restart_Q", 32'(Q), 15);
      check("t4_restart_R", 32'(R), 0);
      check("t4_restart_M", 32'(M), 15);
      tick(3);
      check("t4_s3_done", 32'(done), 0);
      tick();
      check("t4_done", 32'(done), 1);
      check("t4_Q", 32'(Q), 1);
      check("t4_R", 32'(R), 0);

      // reset mid-run
      ctrl = 1'b0;
      do_load(4'd13, 4'd4);
      ctrl = 1'b1;
      tick(2);
      rst_n = 1'b0;
      tick();
      check("t5_rst_Q", 32'(Q), 0);
      check("t5_rst_R", 32'(R), 0);
      check("t5_rst_M", 32'(M), 0);
      check("t5_rst_done", 32'(done), 0);
      rst_n = 1'b1;
      tick(4);
      check("t5_after_R", 32'(R), 0);
      check("t5_after_M", 32'(M), 0);

      // 11 / 0
      ctrl = 1'b0;
      do_load(4'd11, 4'd0);
`ifdef SERIAL_DIVIDER_DIV_ZERO_DETECT_EN
      check("t6_dbz", 32'(div_by_zero), 1);
      check("t6_done", 32'(done), 1);
      check("t6_Q", 32'(Q), 15);
      check("t6_R", 32'(R), 11);
      ctrl = 1'b1;
      tick(2);
      check("t6_hold_Q", 32'(Q), 15);
      check("t6_hold_R", 32'(R), 11);
`else
      check("t6_dbz", 32'(div_by_zero), 0);
      check("t6_load_done", 32'(done), 0);
      ctrl = 1'b1;
      tick(3);
      check("t6_s3_done", 32'(done), 0);
      tick();
      check("t6_done", 32'(done), 1);
      check("t6_Q", 32'(Q), 15);
      check("t6_R", 32'(R), 11);
      check("t6_dbz_end", 32'(div_by_zero), 0);
`endif
      ctrl = 1'b0;
      do_load(4'd13, 4'd4);
      check("t6_clear_dbz", 32'(div_by_zero), 0);
      check("t6_clear_done", 32'(done), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
